uart_rx_mid: RTL and testbench

- Standalone UART receiver. It recovers bytes from an asynchronous serial line: 8 data bits, LSB first, optional parity, 1 stop bit.
- It is the receive end that pairs with the team's UART transmitter path. It is used as the far-end checker in loopback benches and as the RX half of the next top-level revision.
- It samples each bit at mid-bit with a 3-sample majority vote.
- It flags framing and parity errors and emits a one-cycle strobe per completed frame.

---
 rtl/uart_rx_mid.sv | 150 +++++++++++++++
 tb/tb_uart_rx_mid.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mid.sv
// Purpose: UART receiver, 8 data bits LSB first, optional odd/even parity, 1 stop bit, mid-bit 3-sample majority vote.
// Latency: rx falling edge to r_stop is about 2 + 9*CLKS_PER_BIT + MID + 2 clk (+CLKS_PER_BIT with parity).
// Backpressure: none; strobes are single-cycle and must be consumed when they fire.
module uart_rx_mid #(
  parameter int clk_rate    = 1000000,
  parameter int baud_rate   = 9600,
  parameter int parity_mode = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       r_stop,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clk_rate / baud_rate;
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam bit PAR_EN       = (parity_mode != 0);
  localparam bit PAR_ODD      = (parity_mode == 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t CNT_S0   = cnt_t'(MID - 1);
  localparam cnt_t CNT_S1   = cnt_t'(MID);
  localparam cnt_t CNT_DEC  = cnt_t'(MID + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t     r_state;
  logic       r_sync1, r_sync2;
  cnt_t       r_clk_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shreg;
  logic       r_s0, r_s1;
  logic       r_par_bad;

  state_t     w_state_nxt;
  logic       w_rx_s, w_vote, w_decide, w_wrap, w_exp_par;
  logic       w_stop_nxt, w_ferr_nxt, w_perr_nxt;

  assign w_rx_s    = r_sync2;
  assign w_decide  = (r_clk_cnt == CNT_DEC);
  assign w_wrap    = (r_clk_cnt == CNT_LAST);
  // Third vote sample is the live synchronized line at the decision count.
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_exp_par = PAR_ODD ? ~^r_shreg : ^r_shreg;
  assign busy      = (r_state != S_IDLE);

  // Two-flop synchronizer; presets high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and strobe decode; STOP acts at the decision point so frames can abut.
  always_comb begin
    w_state_nxt = r_state;
    w_stop_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_decide && w_vote) w_state_nxt = S_IDLE;
        else if (w_wrap)        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_wrap && (r_bit_idx == 3'd7)) w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_wrap) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_decide) begin
          if (!w_vote) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end else if (r_par_bad) begin
            w_perr_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, vote samples, shift register, parity check and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_par_bad  <= 1'b0;
      data_out   <= '0;
      r_stop     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_BREAK) || w_wrap)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + cnt_t'(1);

      if (r_clk_cnt == CNT_S0) r_s0 <= w_rx_s;
      if (r_clk_cnt == CNT_S1) r_s1 <= w_rx_s;

      if (r_state == S_START)                r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_wrap) r_bit_idx <= r_bit_idx + 3'd1;

      if ((r_state == S_DATA) && w_decide) r_shreg[r_bit_idx] <= w_vote;

      if (r_state == S_IDLE)                     r_par_bad <= 1'b0;
      else if ((r_state == S_PARITY) && w_decide) r_par_bad <= (w_vote != w_exp_par);

      if (w_stop_nxt) data_out <= r_shreg;
      r_stop     <= w_stop_nxt;
      frame_err  <= w_ferr_nxt;
      parity_err <= w_perr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_mid.sv
// Purpose: randomized scoreboard bench for uart_rx_mid; one default instance and one even-parity fast instance.
// Latency: frame outcomes are checked against a window around the nominal frame latency.
// Backpressure: none; the monitor consumes every strobe on the cycle it appears.
module tb_uart_rx_mid;

  localparam int CPB0 = 1000000 / 9600;
  localparam int CPB1 = 160000 / 10000;

  typedef struct {
    int         dut;
    int         kind;   // 0 good byte, 1 framing error, 2 parity error
    logic [7:0] d;
    longint     t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx   [2];
  logic [7:0] dout [2];
  logic       stb  [2];
  logic       ferr [2];
  logic       perr [2];
  logic       bsy  [2];

  exp_t       q[$];
  logic [7:0] last_good [2];
  longint     cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_mid u_dut0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .data_out(dout[0]), .r_stop(stb[0]),
    .frame_err(ferr[0]), .parity_err(perr[0]), .busy(bsy[0])
  );

  uart_rx_mid #(.clk_rate(160000), .baud_rate(10000), .parity_mode(2)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .data_out(dout[1]), .r_stop(stb[1]),
    .frame_err(ferr[1]), .parity_err(perr[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per strobe and compares outcome, data and timing.
  exp_t   me;
  int     mkind;
  longint mlat, mbase;
  bit     mprev [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (stb[i] === 1'b1 || ferr[i] === 1'b1 || perr[i] === 1'b1) begin
        mkind = stb[i] ? 0 : (ferr[i] ? 1 : 2);
        check("single_strobe", int'(stb[i]) + int'(ferr[i]) + int'(perr[i]), 1);
        check("no_adjacent_strobe", mprev[i], 0);
        check("expectation_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          me = q.pop_front();
          check("strobe_dut", i, me.dut);
          check("outcome_kind", mkind, me.kind);
          mbase = 9 * ((i == 1) ? CPB1 : CPB0) + ((i == 1) ? CPB1 : CPB0) / 2 + ((i == 1) ? CPB1 : 0);
          mlat  = cyc - me.t0;
          check("latency_window", (mlat >= mbase + 3) && (mlat <= mbase + 6), 1);
          if (me.kind == 0) last_good[i] = me.d;
        end
        check("data_out", dout[i], last_good[i]);
      end
      mprev[i] = (stb[i] === 1'b1) || (ferr[i] === 1'b1) || (perr[i] === 1'b1);
    end
  end

  task automatic idle(input int dut, input int n);
    @(negedge clk);
    rx[dut] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serializes one frame; optional single-clk glitch and optional reset abort at bit abort_bit.
  task automatic send_frame(input int dut, input logic [7:0] d, input bit stop_b, input bit par_b,
                            input bit glitch, input int abort_bit);
    int   cpb, mid, gbit, goff;
    bit   par_en;
    bit   bits[$];
    bit   val;
    exp_t e;
    cpb    = (dut == 1) ? CPB1 : CPB0;
    mid    = cpb / 2;
    par_en = (dut == 1);
    bits   = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(par_b);
    bits.push_back(stop_b);
    gbit = $urandom_range(bits.size() - 2, 0);
    goff = $urandom_range(mid + 4, mid - 2);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (k == abort_bit && c == cpb / 2) begin
          rst = 1'b0;
          #1;
          for (int i = 0; i < 2; i++) begin
            check("abort_data_out", dout[i], 0);
            check("abort_r_stop", stb[i], 0);
            check("abort_frame_err", ferr[i], 0);
            check("abort_parity_err", perr[i], 0);
            check("abort_busy", bsy[i], 0);
            last_good[i] = 8'h00;
          end
          rx[dut] = 1'b1;
          repeat (3) @(negedge clk);
          rst = 1'b1;
          return;
        end
        if (k == 0 && c == 0 && abort_bit < 0) begin
          e.dut  = dut;
          e.d    = d;
          e.t0   = cyc;
          if (!stop_b)                                         e.kind = 1;
          else if (par_en && ((($countones(d) + par_b) % 2) != 0)) e.kind = 2;
          else                                                 e.kind = 0;
          q.push_back(e);
        end
        val = bits[k];
        if (glitch && k == gbit && c == goff) val = ~val;
        rx[dut] = val;
      end
    end
  endtask

  initial begin
    bit sb, pb, gl;
    logic [7:0] d;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_data_out", dout[i], 0);
      check("reset_r_stop", stb[i], 0);
      check("reset_frame_err", ferr[i], 0);
      check("reset_parity_err", perr[i], 0);
      check("reset_busy", bsy[i], 0);
    end
    rst = 1'b1;
    idle(0, 20);

    // Single clean frame.
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, -1);
    idle(0, 2 * CPB0);
    check("t1_busy_idle", bsy[0], 0);
    check("t1_drained", q.size(), 0);
    check("t1_data", dout[0], 8'hA5);

    // Back-to-back frames.
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, -1);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
    idle(0, 2 * CPB0);
    check("t2_drained", q.size(), 0);
    check("t2_data", dout[0], 8'hFF);

    // Framing error, then held-low break.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    repeat (500) @(negedge clk);
    check("t3_busy_in_break", bsy[0], 1);
    idle(0, 3 * CPB0);
    check("t3_busy_released", bsy[0], 0);
    check("t3_drained", q.size(), 0);
    check("t3_data_held", dout[0], 8'hFF);

    // False start: 20 clk low pulse, then a 1 clk low glitch.
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_start_entered", bsy[0], 1);
    repeat (10) @(negedge clk);
    idle(0, 2 * CPB0);
    check("t4_back_idle", bsy[0], 0);
    @(negedge clk);
    rx[0] = 1'b0;
    idle(0, 2 * CPB0);
    check("t4_glitch_idle", bsy[0], 0);
    check("t4_no_frames", q.size(), 0);

    // Even parity: good then bad parity bit.
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, -1);
    idle(1, 2 * CPB1);
    check("t5_good_data", dout[1], 8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0, -1);
    idle(1, 2 * CPB1);
    check("t5_data_held", dout[1], 8'h07);
    check("t5_drained", q.size(), 0);

    // Reset at data bit 4 midpoint, then a clean frame.
    send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 5);
    idle(0, 2 * CPB0);
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0, -1);
    idle(0, 2 * CPB0);
    check("t6_data", dout[0], 8'h81);
    check("t6_drained", q.size(), 0);

    // Randomized frames on both instances, with glitches and errors.
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(4, 0) != 0);
      gl = $urandom_range(1, 0);
      send_frame(0, d, sb, 1'b0, gl, -1);
      if (!sb) idle(0, 2 * CPB0);
      else if ($urandom_range(1, 0) == 1) idle(0, $urandom_range(3, 0));
    end
    idle(0, 2 * CPB0);
    for (int n = 0; n < 60; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(4, 0) != 0);
      pb = $urandom_range(1, 0);
      gl = $urandom_range(1, 0);
      send_frame(1, d, sb, pb, gl, -1);
      if (!sb) idle(1, 2 * CPB1);
      else if ($urandom_range(1, 0) == 1) idle(1, $urandom_range(3, 0));
    end
    idle(1, 3 * CPB1);
    check("random_drained", q.size(), 0);
    check("random_busy0", bsy[0], 0);
    check("random_busy1", bsy[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
